// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game blocks: launcher state,
// screen bounds and keyboard scan codes.
package tank_pkg;

  typedef enum logic [1:0] {
    LS_IDLE     = 2'd0,
    LS_FLIGHT   = 2'd1,
    LS_COOLDOWN = 2'd2
  } launcher_state_t;

  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;

  localparam logic [7:0] KEY_FIRE = 8'h2C;
  localparam logic [7:0] KEY_UP   = 8'h1A;
  localparam logic [7:0] KEY_DOWN = 8'h16;

endpackage

// File: rtl/key_edge_detect.sv
// Single-cycle pulse on the first cycle a given keycode appears; holding
// the key produces no further pulses until it is released.
module key_edge_detect #(
  parameter logic [7:0] KEY = 8'h2C
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       key_pulse
);

  logic [7:0] prev_keycode;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) prev_keycode <= 8'h00;
    else       prev_keycode <= keycode;
  end

  assign key_pulse = (keycode == KEY) && (prev_keycode != KEY);

endmodule

// File: rtl/bullet_launcher.sv
// Single-bullet launcher: fires from the turret muzzle on a key press, steps
// the bullet once per video frame, and re-arms after a cooldown.
module bullet_launcher
  import tank_pkg::*;
#(
  parameter logic [7:0] FIRE_KEY        = KEY_FIRE,
  parameter int         X_MAX           = SCREEN_X_MAX,
  parameter int         Y_MAX           = SCREEN_Y_MAX,
  parameter int         STEP_SHIFT      = 2,
  parameter int         COOLDOWN_FRAMES = 8,
  parameter int         FLIGHT_MAX      = 255
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic [9:0] motion_x,
  input  logic [9:0] motion_y,
  input  logic [9:0] origin_x,
  input  logic [9:0] origin_y,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       bullet_active,
  output logic       fire_ack,
  output logic [7:0] shots_fired
);

  localparam int FCNT_W = $clog2(FLIGHT_MAX + 1);
  localparam int CCNT_W = $clog2(COOLDOWN_FRAMES + 1);

  launcher_state_t state, state_n;

  logic [9:0]        mot_x, mot_y, mot_x_n, mot_y_n;
  logic [9:0]        bullet_x_n, bullet_y_n;
  logic [FCNT_W-1:0] flight_cnt, flight_cnt_n;
  logic [CCNT_W-1:0] cool_cnt, cool_cnt_n;
  logic [7:0]        shots_n;
  logic              ack_n;
  logic              fire_evt;

  logic signed [11:0] step_x, step_y, next_x, next_y;
  logic               out_of_bounds;

  key_edge_detect #(.KEY(FIRE_KEY)) u_fire_edge (
    .Clk       (Clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .key_pulse (fire_evt)
  );

  // 12-bit signed step keeps negative excursions visible for the bound test.
  assign step_x = $signed({{2{mot_x[9]}}, mot_x}) <<< STEP_SHIFT;
  assign step_y = $signed({{2{mot_y[9]}}, mot_y}) <<< STEP_SHIFT;
  assign next_x = $signed({2'b00, bullet_x}) + step_x;
  assign next_y = $signed({2'b00, bullet_y}) + step_y;
  assign out_of_bounds = (next_x < 0) || (next_x > X_MAX) ||
                         (next_y < 0) || (next_y > Y_MAX);

  always_comb begin
    state_n      = state;
    bullet_x_n   = bullet_x;
    bullet_y_n   = bullet_y;
    mot_x_n      = mot_x;
    mot_y_n      = mot_y;
    flight_cnt_n = flight_cnt;
    cool_cnt_n   = cool_cnt;
    shots_n      = shots_fired;
    ack_n        = 1'b0;
    case (state)
      LS_IDLE: begin
        if (fire_evt) begin
          state_n      = LS_FLIGHT;
          bullet_x_n   = origin_x;
          bullet_y_n   = origin_y;
          mot_x_n      = motion_x;
          mot_y_n      = motion_y;
          flight_cnt_n = '0;
          ack_n        = 1'b1;
          shots_n      = shots_fired + 8'd1;
        end
      end
      LS_FLIGHT: begin
        if (frame_tick) begin
          flight_cnt_n = flight_cnt + 1'b1;
          if (flight_cnt == FCNT_W'(FLIGHT_MAX - 1) || out_of_bounds) begin
            state_n    = LS_COOLDOWN;
            cool_cnt_n = '0;
          end else begin
            bullet_x_n = next_x[9:0];
            bullet_y_n = next_y[9:0];
          end
        end
      end
      LS_COOLDOWN: begin
        if (frame_tick) begin
          cool_cnt_n = cool_cnt + 1'b1;
          if (cool_cnt == CCNT_W'(COOLDOWN_FRAMES - 1)) state_n = LS_IDLE;
        end
      end
      default: state_n = LS_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= LS_IDLE;
      bullet_x      <= '0;
      bullet_y      <= '0;
      mot_x         <= '0;
      mot_y         <= '0;
      flight_cnt    <= '0;
      cool_cnt      <= '0;
      shots_fired   <= '0;
      fire_ack      <= 1'b0;
      bullet_active <= 1'b0;
    end else begin
      state         <= state_n;
      bullet_x      <= bullet_x_n;
      bullet_y      <= bullet_y_n;
      mot_x         <= mot_x_n;
      mot_y         <= mot_y_n;
      flight_cnt    <= flight_cnt_n;
      cool_cnt      <= cool_cnt_n;
      shots_fired   <= shots_n;
      fire_ack      <= ack_n;
      bullet_active <= (state_n == LS_FLIGHT);
    end
  end

endmodule

// File: tb/tb_bullet_launcher.sv
// Directed scenarios plus randomized traffic for bullet_launcher, checked
// every cycle against a plain-integer behavioural model of the launcher.
module tb_bullet_launcher;

  localparam logic [7:0] FIRE = 8'h2C;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] motion_x = '0, motion_y = '0, origin_x = '0, origin_y = '0;
  logic [9:0] bullet_x, bullet_y;
  logic       bullet_active, fire_ack;
  logic [7:0] shots_fired;

  int total = 0;
  int bad = 0;

  // model: phase 0 = ready, 1 = bullet flying, 2 = re-arming
  int m_phase, m_x, m_y, m_dx, m_dy, m_frames, m_cool, m_shots, m_ack;
  logic [7:0] m_lastkey;

  bullet_launcher dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_tick    (frame_tick),
    .keycode       (keycode),
    .motion_x      (motion_x),
    .motion_y      (motion_y),
    .origin_x      (origin_x),
    .origin_y      (origin_y),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .fire_ack      (fire_ack),
    .shots_fired   (shots_fired)
  );

  always #5 Clk = ~Clk;

  function automatic int s10(logic [9:0] v);
    return v[9] ? int'(v) - 1024 : int'(v);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_x = 0; m_y = 0; m_dx = 0; m_dy = 0;
    m_frames = 0; m_cool = 0; m_shots = 0; m_ack = 0; m_lastkey = 8'h00;
  endtask

  task automatic model_step();
    bit fire;
    int nx, ny;
    fire = (keycode == FIRE) && (m_lastkey != FIRE);
    m_lastkey = keycode;
    m_ack = 0;
    if (m_phase == 0) begin
      if (fire) begin
        m_phase = 1; m_x = origin_x; m_y = origin_y;
        m_dx = s10(motion_x) * 4; m_dy = s10(motion_y) * 4;
        m_frames = 0; m_ack = 1; m_shots = (m_shots + 1) % 256;
      end
    end else if (m_phase == 1) begin
      if (frame_tick) begin
        m_frames++;
        nx = m_x + m_dx;
        ny = m_y + m_dy;
        if (m_frames == 255 || nx < 0 || nx > 639 || ny < 0 || ny > 479) begin
          m_phase = 2; m_cool = 0;
        end else begin
          m_x = nx; m_y = ny;
        end
      end
    end else begin
      if (frame_tick) begin
        m_cool++;
        if (m_cool == 8) m_phase = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("bullet_x", 32'(bullet_x), 32'(m_x));
    chk("bullet_y", 32'(bullet_y), 32'(m_y));
    chk("bullet_active", 32'(bullet_active), 32'(m_phase == 1));
    chk("fire_ack", 32'(fire_ack), 32'(m_ack));
    chk("shots_fired", 32'(shots_fired), 32'(m_shots));
  endtask

  task automatic cycle();
    @(posedge Clk);
    if (Reset) model_reset();
    else       model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    keycode = 8'h00;
    frame_tick = 1'b0;
    cycle();
    chk("reset_shots", 32'(shots_fired), 32'd0);
    chk("reset_active", 32'(bullet_active), 32'd0);
    Reset = 1'b0;
  endtask

  task automatic launch(int ox, int oy, logic [9:0] mx, logic [9:0] my);
    origin_x = 10'(ox); origin_y = 10'(oy);
    motion_x = mx; motion_y = my;
    keycode = FIRE;
    cycle();
    keycode = 8'h00;
  endtask

  initial begin
    model_reset();
    do_reset();

    // horizontal flight
    launch(100, 200, 10'd1, 10'd0);
    chk("h_ack", 32'(fire_ack), 32'd1);
    chk("h_shots", 32'(shots_fired), 32'd1);
    chk("h_x0", 32'(bullet_x), 32'd100);
    motion_x = 10'd5;
    cycle();
    chk("h_ack_drop", 32'(fire_ack), 32'd0);
    frame_tick = 1'b1;
    repeat (134) cycle();
    chk("h_x636", 32'(bullet_x), 32'd636);
    chk("h_still_active", 32'(bullet_active), 32'd1);
    cycle();
    chk("h_retired", 32'(bullet_active), 32'd0);
    chk("h_hold_x", 32'(bullet_x), 32'd636);
    repeat (3) cycle();
    keycode = FIRE; cycle(); keycode = 8'h00;
    repeat (3) cycle();
    chk("h_cool_ignore", 32'(shots_fired), 32'd1);
    keycode = FIRE; cycle();
    chk("h_final_tick_fire", 32'(fire_ack), 32'd0);
    keycode = 8'h00; frame_tick = 1'b0; cycle();
    keycode = FIRE; cycle(); keycode = 8'h00;
    chk("h_rearmed_ack", 32'(fire_ack), 32'd1);
    chk("h_rearmed_shots", 32'(shots_fired), 32'd2);

    // steep upward flight
    do_reset();
    launch(320, 10, 10'd0, 10'h3FE);
    frame_tick = 1'b1;
    cycle();
    chk("up_y2", 32'(bullet_y), 32'd2);
    chk("up_active", 32'(bullet_active), 32'd1);
    cycle();
    chk("up_retired", 32'(bullet_active), 32'd0);
    chk("up_hold_y", 32'(bullet_y), 32'd2);
    frame_tick = 1'b0;

    // key hold, then press during flight
    do_reset();
    origin_x = 10'd10; origin_y = 10'd10; motion_x = 10'd1; motion_y = 10'd1;
    keycode = FIRE;
    repeat (50) cycle();
    chk("hold_shots", 32'(shots_fired), 32'd1);
    keycode = 8'h00; cycle();
    keycode = FIRE; cycle(); keycode = 8'h00;
    chk("hold_refire", 32'(shots_fired), 32'd1);
    chk("hold_no_ack", 32'(fire_ack), 32'd0);

    // zero motion retires on the 255th frame
    do_reset();
    launch(50, 60, 10'd0, 10'd0);
    frame_tick = 1'b1;
    repeat (254) cycle();
    chk("zero_active254", 32'(bullet_active), 32'd1);
    chk("zero_x", 32'(bullet_x), 32'd50);
    cycle();
    chk("zero_retired", 32'(bullet_active), 32'd0);
    chk("zero_y", 32'(bullet_y), 32'd60);
    frame_tick = 1'b0;

    // asynchronous reset mid-flight, then fire on the first free cycle
    do_reset();
    launch(300, 300, 10'd2, 10'd1);
    frame_tick = 1'b1;
    repeat (3) cycle();
    Reset = 1'b1;
    #1;
    model_reset();
    chk("arst_x", 32'(bullet_x), 32'd0);
    chk("arst_y", 32'(bullet_y), 32'd0);
    chk("arst_active", 32'(bullet_active), 32'd0);
    chk("arst_shots", 32'(shots_fired), 32'd0);
    chk("arst_ack", 32'(fire_ack), 32'd0);
    frame_tick = 1'b0;
    keycode = FIRE;
    cycle();
    Reset = 1'b0;
    cycle();
    chk("post_rst_ack", 32'(fire_ack), 32'd1);
    chk("post_rst_shots", 32'(shots_fired), 32'd1);
    keycode = 8'h00;

    // launch coincident with a frame tick
    do_reset();
    origin_x = 10'd200; origin_y = 10'd100; motion_x = 10'd2; motion_y = 10'h3FF;
    keycode = FIRE; frame_tick = 1'b1;
    cycle();
    chk("coin_x", 32'(bullet_x), 32'd200);
    chk("coin_y", 32'(bullet_y), 32'd100);
    keycode = 8'h00; frame_tick = 1'b0;
    cycle();
    chk("coin_x_hold", 32'(bullet_x), 32'd200);
    frame_tick = 1'b1;
    cycle();
    chk("coin_x_step", 32'(bullet_x), 32'd208);
    chk("coin_y_step", 32'(bullet_y), 32'd96);
    frame_tick = 1'b0;

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3)      keycode = FIRE;
      else if (r < 7) keycode = keycode;
      else if (r < 9) keycode = 8'h00;
      else            keycode = 8'($urandom);
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) begin
        motion_x = 10'($urandom);
        motion_y = 10'($urandom);
      end else begin
        motion_x = 10'(int'($urandom_range(0, 6)) - 3);
        motion_y = 10'(int'($urandom_range(0, 6)) - 3);
      end
      origin_x = 10'($urandom_range(0, 639));
      origin_y = 10'($urandom_range(0, 479));
      if ($urandom_range(0, 1499) == 0) begin
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bullet_launcher.md
BULLET_LAUNCHER -- requirements
Module: bullet_launcher

Interface
REQ-001 Parameter FIRE_KEY, 8'h2C, keycode that fires a round (space).
REQ-002 Parameter X_MAX, 639, rightmost legal bullet x.
REQ-003 Parameter Y_MAX, 479, bottom legal bullet y.
REQ-004 Parameter STEP_SHIFT, 2, left shift applied to the motion vector per frame.
REQ-005 Parameter COOLDOWN_FRAMES, 8, frame ticks between retire and re-arm.
REQ-006 Parameter FLIGHT_MAX, 255, frame-tick limit on one flight.
REQ-007 The block SHALL use one clock and an asynchronous, active-high reset, with the ports named Clk and Reset.
REQ-008 Clk  in  1  system clock.
REQ-009 Reset  in  1  asynchronous active-high reset.
REQ-010 frame_tick  in  1  one-Clk pulse per video frame.
REQ-011 keycode  in  8  current keyboard keycode.
REQ-012 motion_x, motion_y  in  10 each  two's-complement per-frame direction from the turret angle FSM.
REQ-013 origin_x, origin_y  in  10 each  turret muzzle position, unsigned.
REQ-014 bullet_x, bullet_y  out  10 each  current bullet position.
REQ-015 bullet_active  out  1  high while the bullet is in flight.
REQ-016 fire_ack  out  1  one-Clk pulse on launch.
REQ-017 shots_fired  out  8  launch count, wraps 255->0.

Function
REQ-018 The FSM SHALL have the states IDLE, FLIGHT and COOLDOWN, all clocked on Clk only; no derived or gated clocks.
REQ-019 A fire event SHALL be the Clk cycle where keycode==FIRE_KEY and the previous cycle's keycode!=FIRE_KEY; holding the key SHALL give exactly one event.
REQ-020 In IDLE, a fire event SHALL:
- move the FSM to FLIGHT;
- load bullet_x/y from origin_x/y;
- latch motion_x/y;
- pulse fire_ack;
- increment shots_fired.
All of these SHALL take effect on the next Clk edge.
REQ-021 The motion inputs SHALL be sampled only at launch; later changes to them SHALL NOT affect a flight.
REQ-022 In FLIGHT, on each frame_tick, the block SHALL compute next = pos + (sign-extended latched motion << STEP_SHIFT) in 12-bit signed arithmetic, per axis.
REQ-023 If next_x<0, next_x>X_MAX, next_y<0 or next_y>Y_MAX, then:
- the FSM SHALL go to COOLDOWN;
- bullet_active SHALL drop;
- bullet_x/y SHALL hold their last in-bounds value.
Otherwise bullet_x/y SHALL take the low 10 bits of next.
REQ-024 A flight frame counter SHALL retire the bullet to COOLDOWN on the FLIGHT_MAX-th frame_tick even if it is still in bounds (this covers a zero motion vector).
REQ-025 A frame_tick coincident with the launch cycle SHALL NOT step the bullet; the first step SHALL be the next frame_tick.
REQ-026 Fire events in FLIGHT or COOLDOWN SHALL be ignored and SHALL NOT queue.
REQ-027 COOLDOWN SHALL count COOLDOWN_FRAMES frame_ticks and then return to IDLE.
REQ-028 A fire event in the same cycle as the final cooldown tick SHALL be ignored.
REQ-029 bullet_active SHALL equal (state==FLIGHT), registered.

Reset
REQ-030 On Reset, asynchronously and in any state including mid-flight, the block SHALL:
- enter IDLE;
- set bullet_x, bullet_y, bullet_active, fire_ack, shots_fired and all counters to 0;
- set the previous-keycode register to 8'h00.
REQ-031 The first cycle after Reset deasserts with keycode==FIRE_KEY SHALL count as a fire event.

Structure
REQ-032 A shared package tank_pkg SHALL hold:
- the launcher state enum;
- the screen bounds 639 and 479;
- the key constants 8'h2C, 8'h1A and 8'h16.
REQ-033 One sub-module, key_edge_detect (parameter KEY; outputs a registered-compare rising-edge pulse), SHALL provide the fire event and SHALL be reusable for the turret up/down keys.

Verification
REQ-034 Scenario, horizontal flight: origin (100,200), motion (1,0), fire.
- fire_ack pulses 1 cycle and shots_fired=1.
- Each frame_tick adds 4 to x.
- After x=636, the next tick retires with bullet_x=636.
- After 8 ticks the FSM is back in IDLE.
REQ-035 Scenario, steep upward flight: origin (320,10), motion (0,10'h3FE).
- The first tick gives y=2.
- The second tick gives next=-6, so the FSM goes to COOLDOWN with bullet_y=2.
REQ-036 Scenario, key hold: hold keycode 8'h2C for 50 cycles, then fire again mid-flight.
- Exactly one launch; shots_fired=1.
REQ-037 Scenario, zero motion: motion (0,0).
- The bullet stays at origin.
- It retires on the 255th frame_tick.
REQ-038 Scenario, reset mid-flight: Reset pulse during FLIGHT.
- All outputs read 0 before the next Clk edge.
REQ-039 Scenario, coincident events: fire event and frame_tick in the same cycle in IDLE.
- bullet_x/y equal the origin until the following frame_tick.
